leaf_router_param: RTL
======================

Name: leaf_router_param

Overview:
Parametrised next-generation leaf router for a GPU group. It connects one local GPU port to N_SPINE spine uplinks. Every input has a real FIFO, and every channel uses valid/ready backpressure. The GPU output is shared through round-robin arbitration, and the router counts dropped packets. It sits between a GPU endpoint and the group's spine layer; one instance is used per leaf position.

Parameters:
ROUTER_ID, 3, leaf index inside the group; compared with dest[1:0]
GROUP_ID, 4'b0111, group index; compared with dest[5:2]
DWIDTH, 16, payload width
N_SPINE, 4, number of spine ports; power of two, 2..8
FIFO_DEPTH, 8, entries per input FIFO; power of two, at least 2
SW, $clog2(N_SPINE+1), grant index width (derived, localparam)

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
gpu_in_data  in  DWIDTH  GPU payload
gpu_in_dest  in  6  destination {group[3:0], router[1:0]}
gpu_in_valid  in  1  GPU offer
gpu_in_ready  out  1  equals !gpu_fifo_full
gpu_out_data  out  DWIDTH  payload delivered to the GPU
gpu_out_valid  out  1  registered valid
gpu_out_ready  in  1  GPU accepts
sp_in_data  in  N_SPINE*DWIDTH  spine payloads; slice i is spine i
sp_in_dest  in  N_SPINE*6  spine destinations
sp_in_valid  in  N_SPINE  spine offers
sp_in_ready  out  N_SPINE  bit i equals !sp_fifo_full[i]
sp_out_data  out  N_SPINE*DWIDTH  uplink payloads
sp_out_valid  out  N_SPINE  registered valids
sp_out_ready  in  N_SPINE  spines accept
sp_fifo_full / sp_fifo_empty  out  N_SPINE each  input FIFO status
gpu_fifo_full / gpu_fifo_empty  out  1 each  GPU input FIFO status
busy  out  1  any FIFO non-empty or any output valid
current_grant  out  SW  last GPU-output grant; N_SPINE denotes GPU loopback
drop_count  out  8  saturating count of misrouted spine packets

Behaviour:
- Clocking and reset: one clock, clk. reset is synchronous and active-high. Reset empties all FIFOs and clears every out_valid, drop_count and current_grant, and sets the round-robin pointer to 0. All *_empty outputs are 1 after reset; all *_full outputs are 0.
- Input push: a word is written when valid && ready. FIFO entries are {dest, data}. When full, ready=0 and the input is held off; nothing is lost.
- Routing decision: made at the FIFO head. The head is local when dest[5:2]==GROUP_ID and dest[1:0]==ROUTER_ID.
- GPU FIFO head:
  - Local head: request GPU-output slot N_SPINE (loopback).
  - Otherwise: target spine k = dest[1:0] mod N_SPINE when dest[5:2]==GROUP_ID; k = dest[5:2] mod N_SPINE otherwise.
- Spine FIFO i head:
  - Local head: request GPU-output slot i.
  - Otherwise: pop and discard in 1 cycle, and increment drop_count, saturating at 255. No spine-to-spine forwarding.
- Spine output k:
  - Its only source is the GPU FIFO.
  - The output register loads when it is empty or consumed (!sp_out_valid[k] || sp_out_ready[k]) and the GPU head targets k. The GPU FIFO pops in the same cycle.
- GPU output:
  - Round-robin arbiter over N_SPINE+1 requesters. The search starts at ptr, where ptr = last grant + 1 modulo N_SPINE+1.
  - Arbitration occurs only when the output can load. The winner pops and loads gpu_out_data, and current_grant takes the winner index.
  - With no requesters, ptr and current_grant hold.
- Conflicts and concurrency:
  - The GPU FIFO pops at most once per cycle. If its head targets a stalled output, it blocks; this is head-of-line blocking by design.
  - Simultaneous push and pop on the same FIFO is legal in any state, and the count is unchanged. A push to a full FIFO is allowed in the cycle it pops only if ready was already high; ready is not combinational on pop.
- Latency: an accepted word is visible at the FIFO head the next cycle. Output valid asserts one cycle after that. Minimum latency is 2 cycles; throughput is 1 word per cycle per output.
- Output hold: an output holds data and valid stable while valid && !ready.
- arb_enable is not a port. Arbitration is always enabled.
- Reset mid-transfer: all buffered words and output registers are discarded, with no partial state.

Decomposition:
- Package leaf_router_pkg:
  - Address field slice constants: GRP_MSB=5, GRP_LSB=2, RID_MSB=1, RID_LSB=0.
  - Entry struct / width constant: ENTRY_W = DWIDTH+6.
  - Function is_local(dest, grp, rid).
- Sub-module router_sync_fifo:
  - Parameters WIDTH and DEPTH.
  - Signals push, pop, din, dout (first-word fall-through), full, empty.
  - Pointers carry an extra wrap bit, and full/empty are derived from the pointers.
  - Instantiated N_SPINE+1 times.
- The round-robin arbiter stays inline.

Test Plan:
- Reset and loopback: hold reset for 3 cycles, then send GPU word 0xA5A5 with dest=6'b011111. Expect gpu_out_valid at cycle +2 with data 0xA5A5 and current_grant=4.
- Uplink steering: send GPU dest=6'b011101. Expect the word on sp_out 1 only, with every other sp_out_valid at 0. Send dest=6'b100000. Expect it on spine 0 (8 mod 4).
- Fair arbitration: spines 0..3 each push 3 local words in the same cycle, with gpu_out_ready=1. Expect grants 0,1,2,3,0,1,2,3,... and 12 words out in 12 consecutive cycles.
- Backpressure and full: drive gpu_out_ready=0 and push 9 words on spine 2. Expect sp_in_ready[2]=0 after 8 FIFO entries plus 1 in the output register, sp_fifo_full[2]=1, and no loss. Release ready and expect in-order drain.
- Drops: spine 1 sends 300 words with dest=6'b000000. Expect drop_count to saturate at 255 and gpu_out_valid to stay 0.
- Reset mid-operation: assert reset while FIFOs are half full and outputs are stalled. Next cycle expect all valids 0, all empties 1, drop_count 0, and normal routing afterwards.

Source files
------------

// File: rtl/leaf_router_pkg.sv
// Shared routing constants and destination-decode helpers for the leaf router.
package leaf_router_pkg;
  localparam int DEST_W  = 6;
  localparam int GRP_MSB = 5;
  localparam int GRP_LSB = 2;
  localparam int RID_MSB = 1;
  localparam int RID_LSB = 0;

  function automatic logic is_local(input logic [DEST_W-1:0] dest,
                                    input logic [3:0]        grp,
                                    input logic [1:0]        rid);
    return (dest[GRP_MSB:GRP_LSB] == grp) && (dest[RID_MSB:RID_LSB] == rid);
  endfunction

  // Uplink index for a non-local destination; n_spine is a power of two so masking is the modulo.
  function automatic logic [3:0] spine_target(input logic [DEST_W-1:0] dest,
                                              input logic [3:0]        grp,
                                              input int                n_spine);
    logic [3:0] sel;
    if (dest[GRP_MSB:GRP_LSB] == grp) sel = {2'b00, dest[RID_MSB:RID_LSB]};
    else                              sel = dest[GRP_MSB:GRP_LSB];
    return sel & 4'(n_spine - 1);
  endfunction
endpackage

// File: rtl/leaf_router_param_fifo.sv
// Synchronous first-word-fall-through FIFO; wrap-bit pointers give full/empty.
module router_sync_fifo #(
  parameter int WIDTH = 22,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW:0]      r_wr_ptr;
  logic [AW:0]      r_rd_ptr;
  logic             w_wr_en;
  logic             w_rd_en;

  assign w_wr_en = push && !full;
  assign w_rd_en = pop && !empty;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_wr_en) r_wr_ptr <= r_wr_ptr + (AW+1)'(1);
      if (w_rd_en) r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (w_wr_en) r_mem[r_wr_ptr[AW-1:0]] <= din;
  end

  assign dout  = r_mem[r_rd_ptr[AW-1:0]];
  assign empty = (r_wr_ptr == r_rd_ptr);
  assign full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) && (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
endmodule

// File: rtl/leaf_router_param.sv
// Leaf router: one GPU port and N_SPINE uplinks, buffered inputs, round-robin GPU output,
// saturating count of misrouted spine traffic.
module leaf_router_param
  import leaf_router_pkg::*;
#(
  parameter int         ROUTER_ID  = 3,
  parameter logic [3:0] GROUP_ID   = 4'b0111,
  parameter int         DWIDTH     = 16,
  parameter int         N_SPINE    = 4,
  parameter int         FIFO_DEPTH = 8,
  localparam int        SW         = $clog2(N_SPINE + 1)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [DWIDTH-1:0]         gpu_in_data,
  input  logic [DEST_W-1:0]         gpu_in_dest,
  input  logic                      gpu_in_valid,
  output logic                      gpu_in_ready,
  output logic [DWIDTH-1:0]         gpu_out_data,
  output logic                      gpu_out_valid,
  input  logic                      gpu_out_ready,
  input  logic [N_SPINE*DWIDTH-1:0] sp_in_data,
  input  logic [N_SPINE*DEST_W-1:0] sp_in_dest,
  input  logic [N_SPINE-1:0]        sp_in_valid,
  output logic [N_SPINE-1:0]        sp_in_ready,
  output logic [N_SPINE*DWIDTH-1:0] sp_out_data,
  output logic [N_SPINE-1:0]        sp_out_valid,
  input  logic [N_SPINE-1:0]        sp_out_ready,
  output logic [N_SPINE-1:0]        sp_fifo_full,
  output logic [N_SPINE-1:0]        sp_fifo_empty,
  output logic                      gpu_fifo_full,
  output logic                      gpu_fifo_empty,
  output logic                      busy,
  output logic [SW-1:0]             current_grant,
  output logic [7:0]                drop_count
);
  localparam int            ENTRY_W  = DWIDTH + DEST_W;
  localparam int            NREQ     = N_SPINE + 1;
  localparam logic [1:0]    RID      = 2'(ROUTER_ID);
  localparam logic [SW-1:0] LOOP_IDX = SW'(N_SPINE);

  logic [ENTRY_W-1:0]        w_gpu_head;
  logic [DEST_W-1:0]         w_gpu_dest;
  logic                      w_gpu_local;
  logic [3:0]                w_gpu_tgt;
  logic                      w_gpu_pop;
  logic [ENTRY_W-1:0]        w_sp_head [N_SPINE];
  logic [N_SPINE-1:0]        w_sp_local;
  logic [N_SPINE-1:0]        w_sp_drop;
  logic [N_SPINE-1:0]        w_sp_pop;
  logic [N_SPINE-1:0]        w_sp_can_load;
  logic [N_SPINE-1:0]        w_sp_load;

  logic [NREQ-1:0]           w_req;
  logic [2*NREQ-1:0]         w_req2;
  logic [NREQ-1:0]           w_rot;
  logic [SW-1:0]             w_off;
  logic [SW:0]               w_sum;
  logic [SW-1:0]             w_win;
  logic [SW-1:0]             w_ptr_nxt;
  logic                      w_win_valid;
  logic                      w_gpu_can_load;
  logic                      w_grant;
  logic [DWIDTH-1:0]         w_win_data;
  logic [8:0]                w_drop_sum;

  logic                      r_gpu_out_valid;
  logic [DWIDTH-1:0]         r_gpu_out_data;
  logic [N_SPINE-1:0]        r_sp_out_valid;
  logic [N_SPINE*DWIDTH-1:0] r_sp_out_data;
  logic [SW-1:0]             r_grant;
  logic [SW-1:0]             r_ptr;
  logic [7:0]                r_drop_count;

  router_sync_fifo #(.WIDTH(ENTRY_W), .DEPTH(FIFO_DEPTH)) u_gpu_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (gpu_in_valid),
    .pop   (w_gpu_pop),
    .din   ({gpu_in_dest, gpu_in_data}),
    .dout  (w_gpu_head),
    .full  (gpu_fifo_full),
    .empty (gpu_fifo_empty)
  );

  for (genvar g = 0; g < N_SPINE; g++) begin : g_sp
    router_sync_fifo #(.WIDTH(ENTRY_W), .DEPTH(FIFO_DEPTH)) u_sp_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (sp_in_valid[g]),
      .pop   (w_sp_pop[g]),
      .din   ({sp_in_dest[g*DEST_W +: DEST_W], sp_in_data[g*DWIDTH +: DWIDTH]}),
      .dout  (w_sp_head[g]),
      .full  (sp_fifo_full[g]),
      .empty (sp_fifo_empty[g])
    );

    assign w_sp_local[g]    = is_local(w_sp_head[g][ENTRY_W-1 -: DEST_W], GROUP_ID, RID);
    assign w_sp_drop[g]     = !sp_fifo_empty[g] && !w_sp_local[g];
    assign w_sp_can_load[g] = !r_sp_out_valid[g] || sp_out_ready[g];
    assign w_sp_load[g]     = !gpu_fifo_empty && !w_gpu_local && (w_gpu_tgt == 4'(g))
                              && w_sp_can_load[g];
    // A non-local spine head is discarded immediately, never forwarded to another spine.
    assign w_sp_pop[g]      = w_sp_drop[g] || (w_grant && (w_win == SW'(g)));
  end

  assign w_gpu_dest  = w_gpu_head[ENTRY_W-1 -: DEST_W];
  assign w_gpu_local = is_local(w_gpu_dest, GROUP_ID, RID);
  assign w_gpu_tgt   = spine_target(w_gpu_dest, GROUP_ID, N_SPINE);
  assign w_gpu_pop   = (|w_sp_load) || (w_grant && (w_win == LOOP_IDX));

  // Round-robin: rotate requests so r_ptr sits at bit 0, take the lowest set bit, rotate back.
  assign w_req  = {!gpu_fifo_empty && w_gpu_local, ~sp_fifo_empty & w_sp_local};
  assign w_req2 = {w_req, w_req};
  assign w_rot  = NREQ'(w_req2 >> r_ptr);

  always_comb begin
    w_off = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (w_rot[i]) w_off = SW'(i);
    end
  end

  assign w_sum          = {1'b0, r_ptr} + {1'b0, w_off};
  assign w_win          = (w_sum >= (SW+1)'(NREQ)) ? SW'(w_sum - (SW+1)'(NREQ)) : SW'(w_sum);
  assign w_ptr_nxt      = (w_win == LOOP_IDX) ? '0 : w_win + SW'(1);
  assign w_win_valid    = |w_req;
  assign w_gpu_can_load = !r_gpu_out_valid || gpu_out_ready;
  assign w_grant        = w_gpu_can_load && w_win_valid;

  always_comb begin
    w_win_data = w_gpu_head[DWIDTH-1:0];
    for (int i = 0; i < N_SPINE; i++) begin
      if (w_win == SW'(i)) w_win_data = w_sp_head[i][DWIDTH-1:0];
    end
  end

  always_comb begin
    w_drop_sum = {1'b0, r_drop_count};
    for (int i = 0; i < N_SPINE; i++) begin
      w_drop_sum = w_drop_sum + 9'(w_sp_drop[i]);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_gpu_out_valid <= 1'b0;
      r_gpu_out_data  <= '0;
      r_sp_out_valid  <= '0;
      r_sp_out_data   <= '0;
      r_grant         <= '0;
      r_ptr           <= '0;
      r_drop_count    <= '0;
    end else begin
      if (w_gpu_can_load) r_gpu_out_valid <= w_win_valid;
      if (w_grant) begin
        r_gpu_out_data <= w_win_data;
        r_grant        <= w_win;
        r_ptr          <= w_ptr_nxt;
      end
      for (int k = 0; k < N_SPINE; k++) begin
        if (w_sp_can_load[k]) r_sp_out_valid[k] <= w_sp_load[k];
        if (w_sp_load[k]) r_sp_out_data[k*DWIDTH +: DWIDTH] <= w_gpu_head[DWIDTH-1:0];
      end
      r_drop_count <= (w_drop_sum > 9'd255) ? 8'hFF : w_drop_sum[7:0];
    end
  end

  assign gpu_in_ready  = !gpu_fifo_full;
  assign sp_in_ready   = ~sp_fifo_full;
  assign gpu_out_valid = r_gpu_out_valid;
  assign gpu_out_data  = r_gpu_out_data;
  assign sp_out_valid  = r_sp_out_valid;
  assign sp_out_data   = r_sp_out_data;
  assign current_grant = r_grant;
  assign drop_count    = r_drop_count;
  assign busy          = !gpu_fifo_empty || !(&sp_fifo_empty) || r_gpu_out_valid
                         || (|r_sp_out_valid);
endmodule
